// File: rtl/approx_adder_pipe.sv
// Pipelined approximate adder: the low K bits are OR-ed, the upper bits go through a
// Sklansky prefix adder whose levels are spread over STAGES registers behind a capture register.
module approx_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SEG    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [2:0]       approx_level,
  input  logic [WIDTH-1:0] size_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  input  logic             stat_clr,
  output logic [31:0]      approx_ops,
  output logic [31:0]      total_ops
);

  // Position 0 of the prefix vectors is the carry-in; position i+1 is operand bit i.
  localparam int NB   = WIDTH + 1;
  localparam int LV   = $clog2(NB);
  localparam int PW   = 1 << LV;
  localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [2:0]       lvl;
    logic [WIDTH-1:0] en;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0]    g;
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] en;
  } pre_t;

  // Bits below K are killed (g=p=0) so the only carry entering bit K is a[K-1]&b[K-1].
  function automatic pre_t preprocess(beat_t x);
    pre_t y;
    int   k;
    k = int'(x.lvl) * SEG;
    if (k > WIDTH) k = WIDTH;
    y      = '0;
    y.en   = x.en;
    y.g[0] = (k == 0) ? x.ci : 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < k) begin
        y.h[i] = x.a[i] | x.b[i];
        if ((i == k - 1) && (k < WIDTH)) y.g[i+1] = x.a[i] & x.b[i];
      end else begin
        y.h[i]   = x.a[i] ^ x.b[i];
        y.g[i+1] = x.a[i] & x.b[i];
        y.p[i+1] = x.a[i] ^ x.b[i];
      end
    end
    return y;
  endfunction

  function automatic pre_t levels(pre_t x, int lo, int hi);
    pre_t y;
    pre_t t;
    int   j;
    y = x;
    for (int l = 0; l < LV; l++) begin
      if ((l >= lo) && (l < hi)) begin
        t = y;
        for (int i = 0; i < PW; i++) begin
          if (((i >> l) & 1) == 1) begin
            j      = ((i >> l) << l) - 1;
            t.g[i] = y.g[i] | (y.p[i] & y.g[j]);
            t.p[i] = y.p[i] & y.p[j];
          end
        end
        y = t;
      end
    end
    return y;
  endfunction

  // After the full tree, g[i] is the carry into operand bit i; g[WIDTH] is the carry-out.
  function automatic logic [WIDTH:0] finish_sum(pre_t x, int lo, int hi);
    pre_t y;
    y = levels(x, lo, hi);
    return {y.g[WIDTH], (y.h ^ y.g[WIDTH-1:0]) & y.en};
  endfunction

  beat_t            cap_q, cap_d;
  pre_t             mid_q [NMID];
  pre_t             mid_d [NMID];
  logic [STAGES:0]  vld_q, vld_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic [31:0]      tot_q, tot_d;
  logic [31:0]      apx_q, apx_d;
  logic             adv;
  logic             accept;

  // Handshake: a beat moves on in_valid && in_ready; every stage advances together only
  // when the output slot is empty or being taken (in_ready = !out_valid || out_ready).
  assign adv    = !vld_q[STAGES] || out_ready;
  assign accept = in_valid && adv;

  always_comb begin
    pre_t t;
    int   lo;
    int   hi;
    t     = '0;
    lo    = 0;
    hi    = 0;
    cap_d = cap_q;
    vld_d = vld_q;
    mid_d = mid_q;
    s_d   = s_q;
    co_d  = co_q;
    if (adv) begin
      cap_d.a   = a;
      cap_d.b   = b;
      cap_d.ci  = ci;
      cap_d.lvl = approx_level;
      cap_d.en  = size_enable;
      vld_d     = {vld_q[STAGES-1:0], in_valid};
      for (int j = 0; j < STAGES; j++) begin
        lo = (j * LV) / STAGES;
        hi = ((j + 1) * LV) / STAGES;
        if (j == 0) t = preprocess(cap_q);
        else        t = mid_q[(j == 0) ? 0 : j - 1];
        if (j == STAGES - 1) {co_d, s_d} = finish_sum(t, lo, hi);
        else                 mid_d[(j < NMID) ? j : 0] = levels(t, lo, hi);
      end
    end
  end

  // A clear on the same edge as an accept wins, so that beat is never counted.
  always_comb begin
    tot_d = tot_q;
    apx_d = apx_q;
    if (stat_clr) begin
      tot_d = '0;
      apx_d = '0;
    end else if (accept) begin
      if (tot_q != 32'hFFFF_FFFF) tot_d = tot_q + 32'd1;
      if ((approx_level != 3'd0) && (apx_q != 32'hFFFF_FFFF)) apx_d = apx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      mid_q <= '{default: '0};
      vld_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      tot_q <= '0;
      apx_q <= '0;
    end else begin
      cap_q <= cap_d;
      mid_q <= mid_d;
      vld_q <= vld_d;
      s_q   <= s_d;
      co_q  <= co_d;
      tot_q <= tot_d;
      apx_q <= apx_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = vld_q[STAGES];
  assign s          = s_q;
  assign co         = co_q;
  assign total_ops  = tot_q;
  assign approx_ops = apx_q;

endmodule
